seq_mul_8bit: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier for the calculator datapath, the counterpart of the restoring divider stages. It computes 16-bit products for the multiply operation. One partial-product add/shift runs per clock, with a start/done handshake. It takes operands from the operand registers and hands the product to the result/BCD conversion logic.

---
 rtl/seq_mul_8bit.sv | 100 ++++++++++
 tb/tb_seq_mul_8bit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_8bit.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one partial-product step per clock.
// Start/done handshake; the product is held until the next completion.
module seq_mul_8bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = PROD_W + 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [OP_W-1:0]    mcand;
  logic [CNT_W-1:0]   count;

  logic [OP_W:0]      sum9_c;
  logic [ACC_W-1:0]   acc_next_c;

  // One iteration: conditional add into the high half (keeping the carry), then shift right.
  always_comb begin
    sum9_c = {1'b0, acc[PROD_W-1:OP_W]};
    if (acc[0]) begin
      sum9_c = {1'b0, acc[PROD_W-1:OP_W]} + {1'b0, mcand};
    end
    acc_next_c = {1'b0, sum9_c, acc[OP_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            acc   <= {{(ACC_W-OP_W){1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          acc <= acc_next_c;
          if (count == LAST_ITER) begin
            product <= acc_next_c[PROD_W-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        S_DONE: begin
          done <= 1'b0;
          // Back-to-back: a start seen in the done cycle begins the next operation directly.
          if (start) begin
            mcand <= a;
            acc   <= {{(ACC_W-OP_W){1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_8bit.sv
// Directed bench for seq_mul_8bit: scoreboard of expected products and done cycles,
// checked when the DUT pulses done.
module tb_seq_mul_8bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          total;
  int          bad;

  seq_mul_8bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected product; done is due 9 negedges after the driving negedge.
  task automatic push_exp(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    e.prod = 16'(x) * 16'(y);
    e.cyc  = cyc + 9;
    sb.push_back(e);
  endtask

  task automatic go(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    push_exp(x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL %s_timeout observed=%0d pending expected=0 pending", tag, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: done must match the head entry in value and cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_overlap", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(sb[0].cyc));
          chk("product", 32'(product), 32'(sb[0].prod));
          void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("missed_done", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic: busy for exactly 8 cycles, then one done cycle
    go(8'h0C, 8'h0A);
    for (int i = 0; i < 7; i++) begin
      chk("basic_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("basic_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_done", 32'(done), 32'd0);
    chk("basic_hold", 32'(product), 32'h0078);
    wait_drain("basic");

    // Carry and extremes
    go(8'hFF, 8'hFF);
    wait_drain("ff_ff");
    go(8'h00, 8'hB7);
    wait_drain("zero_a");
    go(8'h80, 8'h02);
    wait_drain("x80_x2");
    go(8'h01, 8'h00);
    wait_drain("zero_b");

    // Start during RUN must be ignored
    go(8'h03, 8'h05);
    @(negedge clk);
    @(negedge clk);
    a = 8'h7F;
    b = 8'h7F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignored");
    repeat (3) @(negedge clk);
    chk("ignored_no_rerun", 32'(busy), 32'd0);
    chk("ignored_hold", 32'(product), 32'h000F);

    // Back-to-back with start held across the done cycle
    @(negedge clk);
    a = 8'h10;
    b = 8'h10;
    start = 1'b1;
    push_exp(8'h10, 8'h10);
    begin
      int n;
      n = 0;
      while (!done && n < 15) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_first_done_seen", 32'(done), 32'd1);
    end
    a = 8'h02;
    b = 8'h03;
    push_exp(8'h02, 8'h03);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restarted", 32'(busy), 32'd1);
    wait_drain("b2b");
    chk("b2b_hold", 32'(product), 32'h0006);

    // Asynchronous reset in the middle of an operation
    go(8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);
    chk("midrst_product_held0", 32'(product), 32'd0);
    rst_n = 1'b1;
    go(8'h02, 8'h02);
    wait_drain("post_rst");

    // Corner operands plus random sweep
    begin
      logic [7:0] corner [6];
      corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          go(corner[i], corner[j]);
          wait_drain("corner");
        end
      end
    end
    for (int k = 0; k < 400; k++) begin
      go(8'($urandom_range(255)), 8'($urandom_range(255)));
      wait_drain("rand");
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
